// File: rtl/eth_rx_frame_if.sv
// Receive-side bundle between the RX pair front end and the RX frame buffer.
// master = eth_rx_frame, slave = line driver / buffer side.
interface eth_rx_frame_if;
  logic        rxd;
  logic        rx_en;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_sof;
  logic        rx_eof;
  logic [10:0] rx_len;
  logic        rx_err;
  logic        rx_busy;

  modport master (
    input  rxd, rx_en,
    output rx_data, rx_valid, rx_sof, rx_eof,
    output rx_len, rx_err, rx_busy
  );

  modport slave (
    output rxd, rx_en,
    input  rx_data, rx_valid, rx_sof, rx_eof,
    input  rx_len, rx_err, rx_busy
  );
endinterface

// File: rtl/eth_rx_frame.sv
// 10BASE-T Manchester receiver: mid-bit clock recovery, preamble/SFD hunt,
// byte assembly and end-of-frame status for the RX buffer.
module eth_rx_frame #(
  parameter int HALF_BIT = 4,
  parameter int MAX_LEN  = 1518,
  parameter int PRE_MIN  = 16
) (
  input  logic           clk,
  input  logic           rst,
  eth_rx_frame_if.master bus
);

  localparam int MID  = (3 * HALF_BIT) / 2;
  localparam int LOSS = 3 * HALF_BIT;
  localparam int CW   = $clog2(LOSS + 1);
  localparam int HW   = $clog2(PRE_MIN + 1);

  typedef enum logic [1:0] {IDLE, HUNT, DATA} state_t;

  state_t      state, state_nxt;
  logic        s1, s2, s3;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [7:0]  sr, sr_nxt;
  logic [2:0]  bit_cnt, bit_cnt_nxt;
  logic [10:0] byte_cnt, byte_cnt_nxt;
  logic [HW-1:0] hunt_bits, hunt_nxt, hunt_inc;
  logic        ovf, ovf_nxt;
  logic [7:0]  data_q, data_nxt;
  logic        valid_q, valid_nxt;
  logic        sof_q, sof_nxt;
  logic        eof_q, eof_nxt;
  logic [10:0] len_q, len_nxt;
  logic        err_q, err_nxt;
  logic        line_edge, mid_edge, loss;

  assign line_edge = s2 ^ s3;

  // In IDLE the first edge seeds bit timing; afterwards only mid-bit edges count.
  always_comb begin
    mid_edge = 1'b0;
    if (line_edge) begin
      if (state == IDLE) mid_edge = bus.rx_en;
      else               mid_edge = (cnt >= CW'(MID));
    end
  end

  assign loss = (state != IDLE) && !mid_edge &&
                (cnt >= CW'(LOSS - 1));

  assign hunt_inc = (hunt_bits == HW'(PRE_MIN)) ?
                    hunt_bits : hunt_bits + HW'(1);

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = (cnt == CW'(LOSS)) ? cnt : cnt + CW'(1);
    sr_nxt       = sr;
    bit_cnt_nxt  = bit_cnt;
    byte_cnt_nxt = byte_cnt;
    hunt_nxt     = hunt_bits;
    ovf_nxt      = ovf;
    data_nxt     = data_q;
    valid_nxt    = 1'b0;
    sof_nxt      = 1'b0;
    eof_nxt      = 1'b0;
    len_nxt      = len_q;
    err_nxt      = err_q;
    if (mid_edge) begin
      cnt_nxt = '0;
      sr_nxt  = {s2, sr[7:1]};
    end
    unique case (state)
      IDLE: begin
        if (mid_edge) begin
          state_nxt = HUNT;
          sr_nxt    = {s2, 7'd0};
          hunt_nxt  = HW'(1);
        end
      end
      HUNT: begin
        if (loss) begin
          state_nxt = IDLE;
        end else if (mid_edge) begin
          hunt_nxt = hunt_inc;
          if (sr_nxt == 8'hD5 && hunt_inc >= HW'(PRE_MIN)) begin
            state_nxt    = DATA;
            sof_nxt      = 1'b1;
            bit_cnt_nxt  = '0;
            byte_cnt_nxt = '0;
            ovf_nxt      = 1'b0;
            len_nxt      = '0;
            err_nxt      = 1'b0;
          end
        end
      end
      DATA: begin
        if (loss) begin
          state_nxt = IDLE;
          eof_nxt   = 1'b1;
          len_nxt   = byte_cnt;
          err_nxt   = (bit_cnt != 3'd0) | ovf | (byte_cnt == 11'd0);
        end else if (mid_edge) begin
          bit_cnt_nxt = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            if (byte_cnt == 11'(MAX_LEN)) begin
              ovf_nxt = 1'b1;
            end else begin
              valid_nxt    = 1'b1;
              data_nxt     = sr_nxt;
              byte_cnt_nxt = byte_cnt + 11'd1;
            end
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1        <= 1'b0;
      s2        <= 1'b0;
      s3        <= 1'b0;
      state     <= IDLE;
      cnt       <= '0;
      sr        <= '0;
      bit_cnt   <= '0;
      byte_cnt  <= '0;
      hunt_bits <= '0;
      ovf       <= 1'b0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      sof_q     <= 1'b0;
      eof_q     <= 1'b0;
      len_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      s1        <= bus.rxd;
      s2        <= s1;
      s3        <= s2;
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      sr        <= sr_nxt;
      bit_cnt   <= bit_cnt_nxt;
      byte_cnt  <= byte_cnt_nxt;
      hunt_bits <= hunt_nxt;
      ovf       <= ovf_nxt;
      data_q    <= data_nxt;
      valid_q   <= valid_nxt;
      sof_q     <= sof_nxt;
      eof_q     <= eof_nxt;
      len_q     <= len_nxt;
      err_q     <= err_nxt;
    end
  end

  assign bus.rx_data  = data_q;
  assign bus.rx_valid = valid_q;
  assign bus.rx_sof   = sof_q;
  assign bus.rx_eof   = eof_q;
  assign bus.rx_len   = len_q;
  assign bus.rx_err   = err_q;
  assign bus.rx_busy  = (state != IDLE);

endmodule

// File: tb/tb_eth_rx_frame.sv
// Bench for eth_rx_frame: Manchester line model driving frames from a table,
// event scoreboard on sof/valid/eof, plus link-pulse and reset sequences.
module tb_eth_rx_frame;

  localparam int HALF = 4;
  localparam int MAXL = 4;

  typedef struct {
    int          kind;
    logic [7:0]  data;
    logic [10:0] len;
    logic        err;
  } ev_t;

  typedef struct {
    int         npre;
    int         n;
    logic [7:0] pl [8];
    int         nx;
    logic [7:0] xb;
    bit         jit;
    bit         den;
    bit         e_sof;
    int         e_len;
    bit         e_err;
  } rec_t;

  logic clk;
  logic rst;
  eth_rx_frame_if bus ();

  eth_rx_frame #(.HALF_BIT(HALF), .MAX_LEN(MAXL), .PRE_MIN(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int  n_tests = 0;
  int  n_fail  = 0;
  int  vcount  = 0;
  int  last_j  = 0;
  ev_t exp_q[$];
  rec_t tbl [7];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic take(input int k);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL unexpected_event: got kind %0d expected none", k);
    end else begin
      e = exp_q.pop_front();
      chk("ev_kind", k, e.kind);
      if (k == 1 && e.kind == 1) chk("rx_data", bus.rx_data, e.data);
      if (k == 2 && e.kind == 2) begin
        chk("rx_len", bus.rx_len, e.len);
        chk("rx_err", bus.rx_err, e.err);
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.rx_sof) take(0);
      if (bus.rx_valid) begin
        take(1);
        vcount++;
      end
      if (bus.rx_eof) take(2);
      if (bus.rx_sof | bus.rx_valid | bus.rx_eof)
        chk("strobe_excl",
            32'(bus.rx_sof) + 32'(bus.rx_valid) + 32'(bus.rx_eof), 1);
    end
  end

  task automatic send_bit(input logic b, input bit jit);
    int j;
    j = jit ? int'($urandom_range(0, 1)) : 0;
    bus.rxd = ~b;
    repeat (HALF + j) @(negedge clk);
    bus.rxd = b;
    repeat (HALF - j) @(negedge clk);
    last_j = j;
  endtask

  task automatic send_byte(input logic [7:0] v, input bit jit);
    for (int i = 0; i < 8; i++) send_bit(v[i], jit);
  endtask

  task automatic wait_idle(input int bound, input string name);
    for (int k = 0; k < bound; k++) begin
      if (!bus.rx_busy) break;
      @(negedge clk);
    end
    chk(name, bus.rx_busy, 0);
  endtask

  // Line held at its last level, then the driver releases it low.
  task automatic tail();
    wait_idle(16 - (HALF - last_j), "eof_idle");
    repeat (8) @(negedge clk);
    if (bus.rxd) begin
      bus.rxd = 1'b0;
      wait_idle(16, "off_idle");
    end
    repeat (10) @(negedge clk);
    chk("q_empty", exp_q.size(), 0);
  endtask

  task automatic push(input int k, input logic [7:0] d,
                      input logic [10:0] l, input logic e);
    ev_t x;
    x.kind = k;
    x.data = d;
    x.len  = l;
    x.err  = e;
    exp_q.push_back(x);
  endtask

  task automatic send_frame(input rec_t r);
    if (r.e_sof) begin
      push(0, 8'h00, 11'd0, 1'b0);
      for (int i = 0; i < r.e_len; i++) push(1, r.pl[i], 11'd0, 1'b0);
      push(2, 8'h00, 11'(r.e_len), r.e_err);
    end
    for (int i = 0; i < r.npre; i++) send_byte(8'h55, r.jit);
    send_byte(8'hD5, r.jit);
    if (r.den) bus.rx_en = 1'b0;
    for (int i = 0; i < r.n; i++) send_byte(r.pl[i], r.jit);
    for (int i = 0; i < r.nx; i++) send_bit(r.xb[i], r.jit);
    tail();
    bus.rx_en = 1'b1;
  endtask

  initial begin
    #(2_000_000);
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rec_t r;
    int   vb;
    tbl[0] = '{7, 4, '{8'h01, 8'h02, 8'h03, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00},
               0, 8'h00, 1'b0, 1'b0, 1'b1, 4, 1'b0};
    tbl[1] = '{7, 2, '{8'hAA, 8'hBB, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
               3, 8'h05, 1'b0, 1'b0, 1'b1, 2, 1'b1};
    tbl[2] = '{7, 6, '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h00, 8'h00},
               0, 8'h00, 1'b0, 1'b0, 1'b1, 4, 1'b1};
    tbl[3] = '{1, 1, '{8'h5A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
               0, 8'h00, 1'b0, 1'b0, 1'b1, 1, 1'b0};
    tbl[4] = '{0, 0, '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
               0, 8'h00, 1'b0, 1'b0, 1'b0, 0, 1'b0};
    tbl[5] = '{7, 3, '{8'hC3, 8'h3C, 8'h96, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
               0, 8'h00, 1'b1, 1'b1, 1'b1, 3, 1'b0};
    tbl[6] = '{7, 0, '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
               0, 8'h00, 1'b0, 1'b0, 1'b1, 0, 1'b1};

    rst = 1'b1;
    bus.rxd = 1'b0;
    bus.rx_en = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_state", {bus.rx_data, bus.rx_valid, bus.rx_sof, bus.rx_eof,
                        bus.rx_len, bus.rx_err, bus.rx_busy}, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    for (int t = 0; t < 7; t++) send_frame(tbl[t]);

    // Normal link pulses must die silently.
    for (int p = 0; p < 3; p++) begin
      bus.rxd = 1'b1;
      repeat (8) @(negedge clk);
      bus.rxd = 1'b0;
      chk("nlp_busy", bus.rx_busy, 1);
      wait_idle(16, "nlp_idle");
      repeat (8) @(negedge clk);
    end
    chk("nlp_q_empty", exp_q.size(), 0);

    bus.rx_en = 1'b0;
    bus.rxd = 1'b1;
    repeat (8) @(negedge clk);
    bus.rxd = 1'b0;
    chk("en_off_busy", bus.rx_busy, 0);
    repeat (16) @(negedge clk);
    chk("en_off_idle", bus.rx_busy, 0);
    bus.rx_en = 1'b1;
    repeat (4) @(negedge clk);

    // Reset after the second byte of a 10-byte frame.
    vb = vcount;
    push(0, 8'h00, 11'd0, 1'b0);
    push(1, 8'h00, 11'd0, 1'b0);
    push(1, 8'hFF, 11'd0, 1'b0);
    fork
      begin
        for (int i = 0; i < 7; i++) send_byte(8'h55, 1'b0);
        send_byte(8'hD5, 1'b0);
        for (int i = 0; i < 10; i++)
          send_byte((i % 2) ? 8'hFF : 8'h00, 1'b0);
      end
      begin
        for (int k = 0; k < 3000; k++) begin
          if (vcount >= vb + 2) break;
          @(negedge clk);
        end
        chk("rst_wait", 32'(vcount >= vb + 2), 1);
        @(posedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        chk("rst_outs", {bus.rx_data, bus.rx_valid, bus.rx_sof, bus.rx_eof,
                         bus.rx_len, bus.rx_err, bus.rx_busy}, 0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
      end
    join
    tail();

    r = '{7, 3, '{8'hA1, 8'hB2, 8'hC3, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
          0, 8'h00, 1'b0, 1'b0, 1'b1, 3, 1'b0};
    send_frame(r);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/eth_rx_frame.md
Name: eth_rx_frame

Overview:
- 10BASE-T Manchester receive datapath; counterpart of the existing eth_frame transmitter.
- Takes the single-bit comparator output of the RX pair, sampled in the eth clock domain, and recovers bit timing from mid-bit transitions.
- Hunts for preamble/SFD, then emits frame bytes LSB-first-assembled with SOF/EOF/status strobes for a downstream RX buffer.

Parameters:
- HALF_BIT, 4, clocks per Manchester half-bit; bit period = 2*HALF_BIT; must be ≥ 3.
- MAX_LEN, 1518, maximum bytes delivered per frame after SFD.
- PRE_MIN, 16, minimum bits received in HUNT, SFD included, before an SFD match is accepted.

Ports:
- clk  input  1  eth clock; all logic on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- rxd  input  1  raw RX line level, asynchronous to clk.
- rx_en  input  1  receive enable; sampled only in IDLE.
- rx_data  output  8  received byte; valid while rx_valid=1.
- rx_valid  output  1  one-cycle strobe, one per byte.
- rx_sof  output  1  one-cycle strobe when SFD is accepted.
- rx_eof  output  1  one-cycle strobe at end of frame.
- rx_len  output  11  byte count of the frame; valid on rx_eof and held until the next rx_sof.
- rx_err  output  1  frame error flag; valid on rx_eof and held until the next rx_sof.
- rx_busy  output  1  high while in HUNT or DATA.

Behaviour:
- Reset: state IDLE; synchronizer flops 0; all outputs 0 (rx_data=8'h00, rx_len=0).
- Input path:
  - rxd passes through a 2-flop synchronizer plus one history flop.
  - An edge is stage2 != stage3. Pin-to-edge latency is fixed at 3 clocks.
- Bit timer:
  - cnt counts clocks since the last accepted transition; it saturates.
  - An edge with cnt < (3*HALF_BIT)/2 is a bit-boundary edge: ignored, cnt keeps counting.
  - An edge with cnt ≥ (3*HALF_BIT)/2 is a mid-bit edge: accepted, cnt←0, bit value = post-edge level (low→high = 1, high→low = 0, matching the transmitter).
  - cnt reaching 3*HALF_BIT with no accepted edge = carrier loss.
- IDLE:
  - Any edge with rx_en=1 → HUNT; that edge counts as an accepted mid-bit edge.
  - rx_en=0 → edges ignored.
- HUNT:
  - Each accepted bit shifts into sr[7] (right shift) and increments hunt_bits, which saturates.
  - sr==8'hD5 and hunt_bits ≥ PRE_MIN → DATA: pulse rx_sof, clear the byte and bit counters.
  - sr==8'hD5 with hunt_bits < PRE_MIN → keep hunting.
  - Carrier loss → IDLE silently: no sof, eof, or err. This discards link pulses and noise.
- DATA:
  - Bits shift into sr[7]. On the 8th bit, the next cycle has rx_data=sr and rx_valid=1, and byte_cnt increments.
  - byte_cnt == MAX_LEN: further bytes are not emitted, byte_cnt saturates, overflow flag is set.
  - Carrier loss → IDLE. Next cycle: rx_eof=1, rx_len=byte_cnt, rx_err = (partial bits ≠ 0) | overflow | (byte_cnt==0).
- rx_en deasserted mid-frame has no effect until IDLE.
- Trailing TP_IDLE level and the driver-off edge after a frame:
  - These may re-enter HUNT.
  - They must end silently via carrier loss.
  - The next frame must still be received; IDLE is reached within 3*HALF_BIT clocks of the final edge.
- Reset asserted mid-frame clears everything immediately. The partial frame is never reported, because a new SFD is required.
- rx_sof, rx_valid and rx_eof are never asserted in the same cycle.
- Edge jitter up to ±1 clock at HALF_BIT=4 must decode correctly.

Test Plan:
1. HALF_BIT=4; send 7×55, D5, 01 02 03 FF, then 3 bit-times of line high → one rx_sof; rx_valid ×4 with 01,02,03,FF; rx_eof with rx_len=4, rx_err=0; rx_busy=0 within 12 clocks of the last edge.
2. Idle line; 8-clock high pulse (NLP), repeated 3 times → no rx_sof, rx_valid or rx_eof; rx_busy returns to 0 each time.
3. Full preamble + D5 + AA BB + 3 extra bits → rx_valid with AA, BB; rx_eof with rx_len=2, rx_err=1.
4. MAX_LEN=4; valid frame with 6 payload bytes → exactly 4 rx_valid; rx_eof with rx_len=4, rx_err=1.
5. PRE_MIN=16:
   - 55 D5 (16 bits) → rx_sof.
   - D5 alone (8 bits) followed by carrier loss → no rx_sof; it is dropped.
6. Assert rst after byte 2 of a 10-byte frame, release 2 clocks later → outputs 0 during reset; no rx_valid or rx_eof for the remainder; the following complete frame is received with correct data and rx_len.
